dsc_mul_seq: RTL and testbench
==============================

// Module: dsc_mul_seq
// PURPOSE
// - Operand sequencer and result capture for the 3-input 8b serial deterministic stochastic multiplier (dsc_mul).
// - Accepts an (a,b,c) operand triple over valid/ready, clears the multiplier, runs it until its ov (done) fires,
//   captures the 24b unary count z, and presents the raw and rounded 8b product over valid/ready.
// - Sits between the host/stream source and dsc_mul; dsc_mul instance is external (ports below drive it).
// PARAMETERS
// - SNG_WIDTH     8         operand width; dsc_mul z width is 3*SNG_WIDTH
// - CLR_CYCLES    2         cycles mul_rst is held asserted before a run (>=1)
// - BLANK_CYCLES  2         cycles after en rises during which mul_ov is ignored
// - TIMEOUT_W     25        width of run-cycle counter; timeout at 2^(3*SNG_WIDTH)+BLANK_CYCLES+4 cycles
// PORTS
// - clk        in   1     single clock, all logic on rising edge
// - rst        in   1     synchronous, active-low reset
// - in_valid   in   1     operand triple valid
// - in_ready   out  1     sequencer can accept a triple (IDLE only)
// - in_a/b/c   in   SNG_WIDTH each   operands, unsigned fractions x/2^SNG_WIDTH
// - mul_a/b/c  out  SNG_WIDTH each   registered operands to dsc_mul a/b/c, stable for whole run
// - mul_rst    out  1     active-high reset to dsc_mul counters/SNGs
// - mul_en     out  1     enable to dsc_mul
// - mul_z      in   3*SNG_WIDTH      dsc_mul result count
// - mul_ov     in   1     dsc_mul done/early-shutoff flag
// - out_valid  out  1     result valid
// - out_ready  in   1     consumer accepts result
// - out_z      out  3*SNG_WIDTH      captured raw count
// - out_q      out  SNG_WIDTH        rounded product: z[23:16] + z[15], saturate at 2^SNG_WIDTH-1
// - out_tmo    out  1     result produced by timeout, not mul_ov
// BEHAVIOUR
// - Reset (rst==0 at edge): state IDLE; in_ready=1 after reset; out_valid=0, out_z=0, out_q=0, out_tmo=0,
//   mul_en=0, mul_rst=1, mul_a/b/c=0. Reset mid-run aborts; no result emitted.
// - FSM: IDLE -> CLR -> RUN -> CAP -> HOLD -> IDLE.
// - IDLE: in_ready=1, mul_rst=1, mul_en=0. On in_valid&in_ready: latch operands into mul_a/b/c, go CLR.
// - CLR: mul_rst=1, mul_en=0 for exactly CLR_CYCLES cycles, then RUN.
// - RUN: mul_rst=0, mul_en=1; cycle counter starts at 0 on entry. mul_ov sampled only when counter>=BLANK_CYCLES.
//   First qualified mul_ov=1 -> CAP. Counter reaching timeout limit with no qualified ov -> CAP with tmo flag set.
//   mul_ov and timeout in same cycle: treated as ov (out_tmo=0).
// - CAP: one cycle, mul_en=0 (freezes z); next edge register out_z=mul_z, out_q, out_tmo; go HOLD.
// - HOLD: out_valid=1, outputs stable; mul_en=0, mul_rst=0 (z held). out_valid&out_ready -> IDLE, out_valid=0 next cycle.
// - Latency in_valid accept -> earliest out_valid: CLR_CYCLES + BLANK_CYCLES + 2 cycles plus run length.
// - Rounding: q = z[3W-1:2W] + z[2W-1]; if carry out (z[3W-1:2W]==all ones and z[2W-1]) q = all ones.
// - in_ready=0 outside IDLE; in_valid outside IDLE is ignored (no buffering). One result in flight max.
// - out_ready high while out_valid low has no effect.
// STRUCTURE
// - Shared package dsc_pkg: SNG_WIDTH, NUM_INPUTS(=3), state enum {IDLE,CLR,RUN,CAP,HOLD}, round/saturate function.
// - One natural sub-module: dsc_round_sat (combinational z -> q); FSM and counters stay in this module.
// TESTING (bench uses behavioural dsc_mul model: z counts to a*b*c over a*b*c+1 en-cycles, ov rises after)
// - Reset hold 3 cycles -> in_ready=1, out_valid=0, mul_rst=1, mul_en=0, all outputs 0.
// - a=b=c=128 -> out_z=0x200000, out_q=0x20, out_tmo=0; mul_rst high exactly 2 cycles before mul_en.
// - a=0,b=200,c=7 with ov immediate -> ov ignored during 2 blank cycles, then out_z=0, out_q=0.
// - a=b=c=255 -> out_z=0xFD02FF, out_q=0xFD (0xFD + bit15=0); z=0xFFFF80 forced -> out_q=0xFF saturated.
// - Model never raises ov -> out_tmo=1 after limit; ov coincident with limit -> out_tmo=0.
// - out_ready held low 10 cycles -> out_valid/out_z stable, in_ready=0, new in_valid ignored; rst low mid-RUN -> IDLE, no out_valid.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared types and helpers for the dsc_mul operand sequencer: sizes, FSM states,
// and the round/saturate step that reduces a 3W-bit unary count to a W-bit product.
package dsc_pkg;

    localparam int SNG_WIDTH  = 8;
    localparam int NUM_INPUTS = 3;
    localparam int Z_W        = NUM_INPUTS * SNG_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        CAP,
        HOLD
    } seq_state_e;

    // w selects the active operand width (w <= SNG_WIDTH) so narrower instances can share it.
    function automatic logic [SNG_WIDTH-1:0] round_sat(input logic [Z_W-1:0] z, input int unsigned w);
        logic [Z_W-1:0] mask;
        logic [Z_W-1:0] hi;
        logic [Z_W-1:0] rb;
        logic [Z_W-1:0] sum;
        mask = (Z_W'(1) << w) - Z_W'(1);
        hi   = (z >> (2 * w)) & mask;
        rb   = (z >> (2 * w - 1)) & Z_W'(1);
        sum  = hi + rb;
        if (sum > mask) begin
            sum = mask;
        end
        return SNG_WIDTH'(sum);
    endfunction

endpackage

// File: rtl/dsc_round_sat.sv
// Combinational reduction of the multiplier count z to a rounded, saturated W-bit product.
module dsc_round_sat
    import dsc_pkg::*;
#(
    parameter int W = dsc_pkg::SNG_WIDTH
) (
    input  logic [NUM_INPUTS*W-1:0] z,
    output logic [W-1:0]            q
);

    logic [Z_W-1:0] z_ext;

    always_comb begin
        z_ext = Z_W'(z);
        q     = W'(round_sat(z_ext, W));
    end

endmodule

// File: rtl/dsc_mul_seq.sv
// Operand sequencer for the serial stochastic multiplier: clears it, runs it until done
// (or timeout), captures the count and offers raw and rounded results over valid/ready.
module dsc_mul_seq
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH    = dsc_pkg::SNG_WIDTH,
    parameter int CLR_CYCLES   = 2,
    parameter int BLANK_CYCLES = 2,
    parameter int TIMEOUT_W    = 25
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SNG_WIDTH-1:0]            in_a,
    input  logic [SNG_WIDTH-1:0]            in_b,
    input  logic [SNG_WIDTH-1:0]            in_c,
    output logic [SNG_WIDTH-1:0]            mul_a,
    output logic [SNG_WIDTH-1:0]            mul_b,
    output logic [SNG_WIDTH-1:0]            mul_c,
    output logic                            mul_rst,
    output logic                            mul_en,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0] mul_z,
    input  logic                            mul_ov,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0] out_z,
    output logic [SNG_WIDTH-1:0]            out_q,
    output logic                            out_tmo
);

    localparam int ZW = NUM_INPUTS * SNG_WIDTH;
    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT =
        TIMEOUT_W'((64'd1 << ZW) + 64'(BLANK_CYCLES) + 64'd4);
    localparam logic [TIMEOUT_W-1:0] CLR_LAST  = TIMEOUT_W'(CLR_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] BLANK_MIN = TIMEOUT_W'(BLANK_CYCLES);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE   = TIMEOUT_W'(1);

    seq_state_e             state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [SNG_WIDTH-1:0]   a_q, a_d;
    logic [SNG_WIDTH-1:0]   b_q, b_d;
    logic [SNG_WIDTH-1:0]   c_q, c_d;
    logic [ZW-1:0]          z_q, z_d;
    logic [SNG_WIDTH-1:0]   q_q, q_d;
    logic                   tmo_flag_q, tmo_flag_d;
    logic                   tmo_q, tmo_d;
    logic [SNG_WIDTH-1:0]   q_round;
    logic                   ov_qual;
    logic                   tmo_hit;

    dsc_round_sat #(
        .W (SNG_WIDTH)
    ) u_round_sat (
        .z (mul_z),
        .q (q_round)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        z_d        = z_q;
        q_d        = q_q;
        tmo_flag_d = tmo_flag_q;
        tmo_d      = tmo_q;
        in_ready   = 1'b0;
        mul_rst    = 1'b0;
        mul_en     = 1'b0;
        out_valid  = 1'b0;
        // ov is blanked right after enable while the multiplier pipeline settles.
        ov_qual    = mul_ov && (cnt_q >= BLANK_MIN);
        tmo_hit    = (cnt_q == TMO_LIMIT);

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                mul_rst  = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    cnt_d   = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                mul_rst = 1'b1;
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                mul_en = 1'b1;
                // A genuine done wins over a timeout landing on the same cycle.
                if (ov_qual) begin
                    tmo_flag_d = 1'b0;
                    state_d    = CAP;
                end else if (tmo_hit) begin
                    tmo_flag_d = 1'b1;
                    state_d    = CAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CAP: begin
                z_d     = mul_z;
                q_d     = q_round;
                tmo_d   = tmo_flag_q;
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            z_q        <= '0;
            q_q        <= '0;
            tmo_flag_q <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            z_q        <= z_d;
            q_q        <= q_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_q      <= tmo_d;
        end
    end

    assign mul_a   = a_q;
    assign mul_b   = b_q;
    assign mul_c   = c_q;
    assign out_z   = z_q;
    assign out_q   = q_q;
    assign out_tmo = tmo_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq with a behavioural multiplier model per instance;
// an 8-bit instance covers the main datapath, a 4-bit one makes the timeout reachable.
module tb_dsc_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance and its multiplier model
    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_tmo8;
    logic [7:0]  in_a8, in_b8, in_c8, mul_a8, mul_b8, mul_c8, out_q8;
    logic        mul_rst8, mul_en8, m8_ov;
    logic [23:0] m8_z, out_z8, prod8, z_force8;
    int          m8_cnt = 0;
    int          run_len8, ov_mode8;
    logic        force_z8, reached8;

    dsc_mul_seq u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_c(in_c8),
        .mul_a(mul_a8), .mul_b(mul_b8), .mul_c(mul_c8),
        .mul_rst(mul_rst8), .mul_en(mul_en8), .mul_z(m8_z), .mul_ov(m8_ov),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_z(out_z8), .out_q(out_q8), .out_tmo(out_tmo8)
    );

    always @(posedge clk) begin
        if (mul_rst8) m8_cnt <= 0;
        else if (mul_en8) m8_cnt <= m8_cnt + 1;
    end

    always_comb begin
        prod8    = 24'(mul_a8) * 24'(mul_b8) * 24'(mul_c8);
        reached8 = (m8_cnt >= run_len8);
        m8_z     = force_z8 ? z_force8 : (reached8 ? prod8 : 24'h0);
        case (ov_mode8)
            1:       m8_ov = 1'b1;
            2:       m8_ov = 1'b0;
            default: m8_ov = reached8;
        endcase
    end

    // 4-bit instance and its multiplier model
    logic        in_valid4, in_ready4, out_valid4, out_ready4, out_tmo4;
    logic [3:0]  in_a4, in_b4, in_c4, mul_a4, mul_b4, mul_c4, out_q4;
    logic        mul_rst4, mul_en4, m4_ov;
    logic [11:0] m4_z, out_z4, prod4;
    int          m4_cnt = 0;
    int          run_len4, ov_mode4;
    logic        reached4;

    dsc_mul_seq #(.SNG_WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_c(in_c4),
        .mul_a(mul_a4), .mul_b(mul_b4), .mul_c(mul_c4),
        .mul_rst(mul_rst4), .mul_en(mul_en4), .mul_z(m4_z), .mul_ov(m4_ov),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_z(out_z4), .out_q(out_q4), .out_tmo(out_tmo4)
    );

    always @(posedge clk) begin
        if (mul_rst4) m4_cnt <= 0;
        else if (mul_en4) m4_cnt <= m4_cnt + 1;
    end

    always_comb begin
        prod4    = 12'(mul_a4) * 12'(mul_b4) * 12'(mul_c4);
        reached4 = (m4_cnt >= run_len4);
        m4_z     = reached4 ? prod4 : 12'h0;
        m4_ov    = (ov_mode4 == 2) ? 1'b0 : reached4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        in_a8 = a; in_b8 = b; in_c8 = c; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait8(input string tag, input int bound);
        int n = 0;
        while (!out_valid8 && n < bound) begin
            step();
            n++;
        end
        chk(tag, 32'(out_valid8), 32'd1);
    endtask

    task automatic take8();
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        chk("take8_valid_low", 32'(out_valid8), 32'd0);
        chk("take8_in_ready", 32'(in_ready8), 32'd1);
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        in_a4 = a; in_b4 = b; in_c4 = c; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait4(input string tag, input int bound);
        int n = 0;
        while (!out_valid4 && n < bound) begin
            step();
            n++;
        end
        chk(tag, 32'(out_valid4), 32'd1);
    endtask

    initial begin
        int vcount;
        logic [23:0] held_z;
        rst = 1'b0;
        in_valid8 = 0; in_a8 = 0; in_b8 = 0; in_c8 = 0; out_ready8 = 0;
        in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_c4 = 0; out_ready4 = 0;
        run_len8 = 4; ov_mode8 = 0; force_z8 = 0; z_force8 = 24'h0;
        run_len4 = 4; ov_mode4 = 0;

        // Reset state after 3 cycles low
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready8), 32'd1);
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_mul_rst", 32'(mul_rst8), 32'd1);
        chk("rst_mul_en", 32'(mul_en8), 32'd0);
        chk("rst_out_z", 32'(out_z8), 32'd0);
        chk("rst_out_q", 32'(out_q8), 32'd0);
        chk("rst_out_tmo", 32'(out_tmo8), 32'd0);
        chk("rst_mul_abc", {8'h0, mul_a8, mul_b8, mul_c8}, 32'd0);
        rst = 1'b1;
        step();

        // 128^3: clear for exactly two cycles, then enabled; latency 2+4+2 = 8
        run_len8 = 4; ov_mode8 = 0;
        send8(8'd128, 8'd128, 8'd128);
        chk("clr0_rst_en", {mul_rst8, mul_en8}, 32'b10);
        chk("clr0_in_ready", 32'(in_ready8), 32'd0);
        step();
        chk("clr1_rst_en", {mul_rst8, mul_en8}, 32'b10);
        step();
        chk("run0_rst_en", {mul_rst8, mul_en8}, 32'b01);
        wait8("t128_valid", 50);
        chk("t128_lat", cyc - acc_cyc, 32'd8);
        chk("t128_z", 32'(out_z8), 32'h200000);
        chk("t128_q", 32'(out_q8), 32'h20);
        chk("t128_tmo", 32'(out_tmo8), 32'd0);
        take8();

        // Immediate ov is blanked: first qualified at run count 2 -> latency 6
        ov_mode8 = 1;
        send8(8'd0, 8'd200, 8'd7);
        wait8("blank_valid", 50);
        chk("blank_lat", cyc - acc_cyc, 32'd6);
        chk("blank_z", 32'(out_z8), 32'h0);
        chk("blank_q", 32'(out_q8), 32'h0);
        take8();

        // 255^3 = 0xFD02FF, bit 15 clear -> no round-up
        ov_mode8 = 0; run_len8 = 3;
        send8(8'd255, 8'd255, 8'd255);
        wait8("t255_valid", 50);
        chk("t255_lat", cyc - acc_cyc, 32'd7);
        chk("t255_z", 32'(out_z8), 32'hFD02FF);
        chk("t255_q", 32'(out_q8), 32'hFD);
        take8();

        // Forced counts: saturation, round-down, round-up
        force_z8 = 1; run_len8 = 2;
        z_force8 = 24'hFFFF80;
        send8(8'd1, 8'd1, 8'd1);
        wait8("sat_valid", 50);
        chk("sat_z", 32'(out_z8), 32'hFFFF80);
        chk("sat_q", 32'(out_q8), 32'hFF);
        take8();
        z_force8 = 24'h127FFF;
        send8(8'd1, 8'd1, 8'd1);
        wait8("rdn_valid", 50);
        chk("rdn_q", 32'(out_q8), 32'h12);
        take8();
        z_force8 = 24'h128000;
        send8(8'd1, 8'd1, 8'd1);
        wait8("rup_valid", 50);
        chk("rup_q", 32'(out_q8), 32'h13);

        // Backpressure: result held, new triple ignored
        held_z = out_z8;
        in_a8 = 8'd9; in_b8 = 8'd9; in_c8 = 8'd9; in_valid8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 32'(out_valid8), 32'd1);
            chk("bp_z", 32'(out_z8), 32'(held_z));
            chk("bp_in_ready", 32'(in_ready8), 32'd0);
        end
        in_valid8 = 1'b0;
        take8();
        chk("bp_no_latch", 32'(mul_a8), 32'd1);
        force_z8 = 0;

        // Reset in the middle of a run aborts it
        run_len8 = 30;
        send8(8'd2, 8'd3, 8'd4);
        repeat (5) step();
        chk("mid_in_run", 32'(mul_en8), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_in_ready", 32'(in_ready8), 32'd1);
        chk("mid_rst_en", {mul_rst8, mul_en8}, 32'b10);
        chk("mid_out_z", 32'(out_z8), 32'h0);
        chk("mid_mul_a", 32'(mul_a8), 32'h0);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid8) vcount++;
        end
        chk("mid_no_result", 32'(vcount), 32'd0);
        run_len8 = 3;
        send8(8'd2, 8'd3, 8'd4);
        wait8("recover_valid", 50);
        chk("recover_z", 32'(out_z8), 32'd24);
        take8();

        // Timeout on 4-bit instance: limit 4096+2+4 = 4102, latency 2+4103+1 = 4106
        ov_mode4 = 2; run_len4 = 100;
        send4(4'd3, 4'd5, 4'd7);
        wait4("tmo_valid", 5000);
        chk("tmo_lat", cyc - acc_cyc, 32'd4106);
        chk("tmo_flag", 32'(out_tmo4), 32'd1);
        chk("tmo_z", 32'(out_z4), 32'd105);
        chk("tmo_q", 32'(out_q4), 32'd0);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        chk("tmo_take", 32'(out_valid4), 32'd0);

        // ov lands on the limit cycle -> treated as ov
        ov_mode4 = 0; run_len4 = 4102;
        send4(4'd15, 4'd15, 4'd15);
        wait4("coin_valid", 5000);
        chk("coin_lat", cyc - acc_cyc, 32'd4106);
        chk("coin_flag", 32'(out_tmo4), 32'd0);
        chk("coin_z", 32'(out_z4), 32'hD2F);
        chk("coin_q", 32'(out_q4), 32'hD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
